// File: rtl/rgb888_to_rgb565_frame_writer.sv
// rgb888_to_rgb565_frame_writer: RGB888 to RGB565/BGR565/gray565 converter with frame-buffer address generation.
// Define RGB565_ROUND_EN for round-to-nearest with saturation instead of truncation.
module rgb888_to_rgb565_frame_writer #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 408,
  parameter int LINE_STRIDE = 320,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_WIDTH  = 17
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [23:0]           i_data_rgb888,
  input  logic                  i_valid,
  input  logic                  i_sof,
  input  logic [1:0]            i_mode,
  output logic                  o_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [15:0]           o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_frame_done,
  output logic                  o_err_sof
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t                state_q;
  logic [XW-1:0]         x_q, x_d, cx;
  logic [YW-1:0]         y_q, y_d, cy;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, ca;
  logic [1:0]            mode_q, md;
  logic                  accept, sof, take, x_end, last, xfer;
  logic [7:0]            r, g, b, y8;
  logic [15:0]           ysum, pix;
  function automatic logic [4:0] q5(input logic [7:0] v);
`ifdef RGB565_ROUND_EN
    logic [8:0] s;
    s = 9'(v) + 9'd4;
    return s > 9'd255 ? 5'd31 : 5'(s >> 3);
`else
    return 5'(v >> 3);
`endif
  endfunction
  function automatic logic [5:0] q6(input logic [7:0] v);
`ifdef RGB565_ROUND_EN
    logic [8:0] s;
    s = 9'(v) + 9'd2;
    return s > 9'd255 ? 6'd63 : 6'(s >> 2);
`else
    return 6'(v >> 2);
`endif
  endfunction
  always_comb begin
    o_ready = state_q != FLUSH && (!o_valid || i_ready);
    accept  = i_valid && o_ready;
    sof     = accept && i_sof;
    take    = sof || (accept && state_q == RUN);
    xfer    = o_valid && i_ready;
    // a sof pixel always restarts the raster at (0,0), even mid-frame
    cx      = sof ? '0 : x_q;
    cy      = sof ? '0 : y_q;
    ca      = sof ? ADDR_WIDTH'(BASE_ADDR) : addr_q;
    md      = sof ? i_mode : mode_q;
    x_end   = cx == XW'(H_ACTIVE - 1);
    last    = x_end && cy == YW'(V_ACTIVE - 1);
    x_d     = x_end ? '0 : cx + XW'(1);
    y_d     = x_end ? cy + YW'(1) : cy;
    addr_d  = ca + (x_end ? ADDR_WIDTH'(LINE_STRIDE - H_ACTIVE + 1) : ADDR_WIDTH'(1));
    r       = i_data_rgb888[23:16];
    g       = i_data_rgb888[15:8];
    b       = i_data_rgb888[7:0];
    ysum    = 16'd77 * 16'(r) + 16'd150 * 16'(g) + 16'd29 * 16'(b);
    y8      = 8'(ysum >> 8);
    pix     = md == 2'b01 ? {q5(b), q6(g), q5(r)} :
              md == 2'b10 ? {q5(y8), q6(y8), q5(y8)} : {q5(r), q6(g), q5(b)};
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      mode_q       <= 2'b00;
      o_valid      <= 1'b0;
      o_addr       <= '0;
      o_data       <= '0;
      o_last       <= 1'b0;
      o_frame_done <= 1'b0;
      o_err_sof    <= 1'b0;
    end else begin
      o_frame_done <= state_q == FLUSH && xfer;
      o_err_sof    <= sof && state_q == RUN;
      if (take) begin
        o_valid <= 1'b1;
        o_addr  <= ca;
        o_data  <= pix;
        o_last  <= last;
        x_q     <= x_d;
        y_q     <= y_d;
        addr_q  <= addr_d;
        mode_q  <= md;
        state_q <= last ? FLUSH : RUN;
      end else if (xfer) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
        if (state_q == FLUSH) begin
          state_q <= IDLE;
          x_q     <= '0;
          y_q     <= '0;
          addr_q  <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rgb888_to_rgb565_frame_writer.sv
// tb_rgb888_to_rgb565_frame_writer: randomized and directed stimulus against a pixel-index reference model.
module tb_rgb888_to_rgb565_frame_writer;
  localparam int H = 4, V = 2, S = 8, B = 16, AW = 8;
  logic clk = 0, rst_n = 0;
  logic [23:0] din = '0;
  logic i_valid = 0, i_sof = 0, i_ready = 1;
  logic [1:0] i_mode = '0;
  logic o_ready, o_valid, o_last, o_frame_done, o_err_sof;
  logic [AW-1:0] o_addr;
  logic [15:0] o_data;
  int checks = 0, passed = 0, stall = 0, fd_cnt = 0, err_cnt = 0;
  bit rnd = 0;
  int la[$], ld[$], ll[$];
  int addrs[8] = '{16, 17, 18, 19, 24, 25, 26, 27};
  bit m_valid = 0, m_last = 0, m_run = 0, m_flush = 0, m_fd = 0, m_err = 0;
  int m_addr = 0, m_data = 0, n = 0, m_mode = 0;

  rgb888_to_rgb565_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_STRIDE(S), .BASE_ADDR(B), .ADDR_WIDTH(AW)) dut (
    .iClk(clk), .iRst_n(rst_n), .i_data_rgb888(din), .i_valid(i_valid), .i_sof(i_sof), .i_mode(i_mode),
    .o_ready(o_ready), .o_addr(o_addr), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_frame_done(o_frame_done), .o_err_sof(o_err_sof));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int q5(input int v);
`ifdef RGB565_ROUND_EN
    return (v + 4) / 8 > 31 ? 31 : (v + 4) / 8;
`else
    return v / 8;
`endif
  endfunction
  function automatic int q6(input int v);
`ifdef RGB565_ROUND_EN
    return (v + 2) / 4 > 63 ? 63 : (v + 2) / 4;
`else
    return v / 4;
`endif
  endfunction
  function automatic int conv(input logic [23:0] p, input int m);
    int r, g, b, y;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    y = (77 * r + 150 * g + 29 * b) / 256;
    if (m == 1) return q5(b) * 2048 + q6(g) * 32 + q5(r);
    if (m == 2) return q5(y) * 2048 + q6(y) * 32 + q5(y);
    return q5(r) * 2048 + q6(g) * 32 + q5(b);
  endfunction

  // reference: output register as one beat slot, pixel position from a flat index n
  task automatic step();
    bit rdy, acc, tr;
    rdy = !m_flush && (!m_valid || i_ready);
    acc = i_valid && rdy;
    tr = m_valid && i_ready;
    m_fd = m_flush && tr;
    m_err = acc && i_sof && m_run;
    if (tr) m_valid = 0;
    if (m_fd) m_flush = 0;
    if (acc && i_sof) begin
      m_mode = i_mode == 2'd3 ? 0 : int'(i_mode);
      n = 0;
      m_run = 1;
    end
    if (acc && m_run) begin
      m_addr = B + (n / H) * S + n % H;
      m_data = conv(din, m_mode);
      m_last = n == H * V - 1;
      m_valid = 1;
      n++;
      if (m_last) begin
        m_run = 0;
        m_flush = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_valid = 0; m_last = 0; m_run = 0; m_flush = 0; m_fd = 0; m_err = 0;
      m_addr = 0; m_data = 0; n = 0; m_mode = 0;
    end else step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_addr", 32'(o_addr), 0);
      chk("rst_data", 32'(o_data), 0);
      chk("rst_last", 32'(o_last), 0);
      chk("rst_done", 32'(o_frame_done), 0);
      chk("rst_err", 32'(o_err_sof), 0);
      chk("rst_ready", 32'(o_ready), 1);
    end else begin
      chk("valid", 32'(o_valid), 32'(m_valid));
      chk("ready", 32'(o_ready), 32'(!m_flush && (!m_valid || i_ready)));
      chk("frame_done", 32'(o_frame_done), 32'(m_fd));
      chk("err_sof", 32'(o_err_sof), 32'(m_err));
      if (m_valid) begin
        chk("addr", 32'(o_addr), m_addr);
        chk("data", 32'(o_data), m_data);
        chk("last", 32'(o_last), 32'(m_last));
      end
      if (o_valid && i_ready) begin
        la.push_back(int'(o_addr));
        ld.push_back(int'(o_data));
        ll.push_back(int'(o_last));
      end
      if (o_frame_done) fd_cnt++;
      if (o_err_sof) err_cnt++;
    end
  end

  task automatic cyc(input bit v, input bit s, input logic [23:0] d, input logic [1:0] m, output bit acc);
    i_valid = v; i_sof = s; din = d; i_mode = m;
    i_ready = stall > 0 ? 1'b0 : (rnd ? $urandom_range(0, 3) != 0 : 1'b1);
    if (stall > 0) stall--;
    #1 acc = v && o_ready;
    @(posedge clk);
    #1;
  endtask
  task automatic send_px(input logic [23:0] d, input bit s, input logic [1:0] m);
    bit a;
    int t = 0;
    do begin
      cyc(1, s, d, m, a);
      t++;
    end while (!a && t < 50);
    if (!a) chk("accept_timeout", 0, 1);
  endtask
  task automatic drain(input int k);
    bit a;
    repeat (k) cyc(0, 0, '0, '0, a);
  endtask
  task automatic send_frame(input logic [23:0] d, input logic [1:0] m);
    send_px(d, 1, m);
    repeat (7) send_px(d, 0, m);
    drain(4);
  endtask
  task automatic clr();
    la.delete(); ld.delete(); ll.delete();
    fd_cnt = 0; err_cnt = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    send_frame(24'hFF8040, 2'd0);
    chk("t2_beats", la.size(), 8);
    if (la.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("t2_addr", la[i], addrs[i]);
        chk("t2_data", ld[i], 32'hFC08);
        chk("t2_last", ll[i], i == 7 ? 1 : 0);
      end
    chk("t2_done", fd_cnt, 1);
    clr();
    send_frame(24'hFF8040, 2'd1);
    chk("t3_bgr", ld.size() > 0 ? ld[0] : -1, 32'h441F);
    clr();
    send_px(24'hFFFFFF, 1, 2'd2);
    repeat (3) send_px(24'hFFFFFF, 0, 2'd0);
    repeat (4) send_px(24'h000000, 0, 2'd1);
    drain(4);
    chk("t3_gray_white", ld.size() == 8 ? ld[0] : -1, 32'hFFFF);
    chk("t3_gray_black", ld.size() == 8 ? ld[7] : -1, 32'h0000);
    clr();
    send_frame(24'h070307, 2'd0);
`ifdef RGB565_ROUND_EN
    chk("t6_small", ld.size() > 0 ? ld[0] : -1, 32'h0821);
`else
    chk("t6_small", ld.size() > 0 ? ld[0] : -1, 32'h0000);
`endif
    clr();
    send_frame(24'hFFFFFF, 2'd3);
    chk("t6_white", ld.size() > 0 ? ld[0] : -1, 32'hFFFF);
    clr();
    send_px(24'h102030, 1, 2'd0);
    repeat (3) send_px(24'h405060, 0, 2'd0);
    stall = 3;
    repeat (4) send_px(24'h708090, 0, 2'd0);
    drain(4);
    chk("t4_beats", la.size(), 8);
    if (la.size() == 8)
      for (int i = 0; i < 8; i++) chk("t4_addr", la[i], addrs[i]);
    clr();
    send_px(24'h112233, 1, 2'd0);
    repeat (4) send_px(24'h445566, 0, 2'd0);
    send_px(24'h778899, 1, 2'd1);
    repeat (6) send_px(24'hAABBCC, 0, 2'd0);
    drain(3);
    chk("t5_no_done_yet", fd_cnt, 0);
    send_px(24'hDDEEFF, 0, 2'd0);
    drain(4);
    chk("t5_err", err_cnt, 1);
    chk("t5_done", fd_cnt, 1);
    chk("t5_beats", la.size(), 13);
    chk("t5_restart_addr", la.size() == 13 ? la[5] : -1, 32'h10);
    chk("t5_last", ll.size() == 13 ? ll[12] : -1, 1);
    clr();
    send_px(24'h123456, 1, 2'd0);
    repeat (3) send_px(24'h654321, 0, 2'd0);
    rst_n = 0;
    drain(2);
    rst_n = 1;
    clr();
    repeat (4) send_px(24'($urandom), 0, 2'($urandom));
    drain(3);
    chk("t1_no_beats", la.size(), 0);
    rnd = 1;
    for (int f = 0; f < 30; f++) begin
      send_px(24'($urandom), 1, 2'($urandom));
      for (int k = 1; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) drain(1);
        send_px(24'($urandom), $urandom_range(0, 15) == 0, 2'($urandom));
      end
      if ($urandom_range(0, 2) == 0) send_px(24'($urandom), 0, 2'($urandom));
      drain($urandom_range(0, 4));
    end
    drain(20);
    rnd = 0;
    drain(4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
